// File: rtl/branch_resolver_if.sv
// branch_resolver_if: branch request / flag write / redirect bus between decode,
// the compare unit, fetch and the branch resolver.
`default_nettype none

interface branch_resolver_if #(
   parameter int ADDR_W = 18,
   parameter int OFF_W  = 10
);
   logic              flag_we;
   logic              zf_in;
   logic              cf_in;
   logic              br_valid;
   logic              br_ready;
   logic [2:0]        br_cond;
   logic [ADDR_W-1:0] br_pc;
   logic [OFF_W-1:0]  br_offset;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              flush;

   modport master (
      output flag_we, zf_in, cf_in, br_valid, br_cond, br_pc, br_offset,
      input  br_ready, redirect_valid, redirect_pc, flush
   );

   modport slave (
      input  flag_we, zf_in, cf_in, br_valid, br_cond, br_pc, br_offset,
      output br_ready, redirect_valid, redirect_pc, flush
   );
endinterface

`default_nettype wire

// File: rtl/branch_resolver.sv
// branch_resolver: holds ZF/CF, evaluates branch conditions, and issues a
// one-cycle PC redirect followed by a pipeline flush on taken branches.
`default_nettype none

module branch_resolver #(
   parameter int ADDR_W       = 18,
   parameter int OFF_W        = 10,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   branch_resolver_if.slave    bus,
   output logic                zf_q,
   output logic                cf_q,
   output logic [CNT_W-1:0]    taken_count
);

   localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [FCNT_W-1:0] fcnt;
   logic [FCNT_W-1:0] fcnt_next;
   logic [ADDR_W-1:0] target_q;

   logic              flush_now;
   logic              flag_wr;
   logic              eff_z;
   logic              eff_c;
   logic              cond_true;
   logic              accept;
   logic              take;
   logic [ADDR_W-1:0] offset_ext;
   logic [ADDR_W-1:0] target;

   assign flush_now = (state != IDLE);
   assign flag_wr   = bus.flag_we && !flush_now;

   // Same-cycle flag writes are forwarded so a compare and its branch can pair up.
   assign eff_z = flag_wr ? bus.zf_in : zf_q;
   assign eff_c = flag_wr ? bus.cf_in : cf_q;

   always_comb begin
      cond_true = 1'b0;
      case (bus.br_cond)
         3'b000:  cond_true = 1'b0;
         3'b001:  cond_true = 1'b1;
         3'b010:  cond_true = eff_z;
         3'b011:  cond_true = !eff_z;
         3'b100:  cond_true = eff_c;
         3'b101:  cond_true = !eff_c && !eff_z;
         3'b110:  cond_true = eff_c || eff_z;
         3'b111:  cond_true = !eff_c;
         default: cond_true = 1'b0;
      endcase
   end

   assign accept     = bus.br_valid && bus.br_ready;
   assign take       = accept && cond_true;
   assign offset_ext = {{(ADDR_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
   assign target     = bus.br_pc + offset_ext;

   assign bus.br_ready       = rst && (state == IDLE);
   assign bus.redirect_valid = (state == REDIRECT);
   assign bus.flush          = flush_now;
   assign bus.redirect_pc    = target_q;

   always_comb begin
      next_state = state;
      fcnt_next  = fcnt;
      case (state)
         IDLE: begin
            if (take) next_state = REDIRECT;
         end
         REDIRECT: begin
            if (FLUSH_CYCLES > 1) begin
               next_state = FLUSH;
               fcnt_next  = FCNT_W'(FLUSH_CYCLES - 1);
            end else begin
               next_state = IDLE;
            end
         end
         FLUSH: begin
            if (fcnt <= FCNT_W'(1)) next_state = IDLE;
            else                    fcnt_next  = fcnt - FCNT_W'(1);
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         fcnt        <= '0;
         zf_q        <= 1'b0;
         cf_q        <= 1'b0;
         target_q    <= '0;
         taken_count <= '0;
      end else begin
         state <= next_state;
         fcnt  <= fcnt_next;
         if (flag_wr) begin
            zf_q <= bus.zf_in;
            cf_q <= bus.cf_in;
         end
         if (take) begin
            target_q <= target;
            if (taken_count != {CNT_W{1'b1}}) taken_count <= taken_count + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: vector table plus hand sequences, with a redirect-target
// scoreboard; a second instance with CNT_W=2 checks counter saturation.
`default_nettype none

module tb_branch_resolver;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   branch_resolver_if #(.ADDR_W(18), .OFF_W(10)) bif ();
   branch_resolver_if #(.ADDR_W(18), .OFF_W(10)) bif2 ();

   logic        zf_q, cf_q, zf_q2, cf_q2;
   logic [15:0] taken_count;
   logic [1:0]  taken_count2;

   branch_resolver #(.ADDR_W(18), .OFF_W(10), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bif.slave),
      .zf_q(zf_q), .cf_q(cf_q), .taken_count(taken_count)
   );

   assign bif2.flag_we   = bif.flag_we;
   assign bif2.zf_in     = bif.zf_in;
   assign bif2.cf_in     = bif.cf_in;
   assign bif2.br_valid  = bif.br_valid;
   assign bif2.br_cond   = bif.br_cond;
   assign bif2.br_pc     = bif.br_pc;
   assign bif2.br_offset = bif.br_offset;

   branch_resolver #(.ADDR_W(18), .OFF_W(10), .FLUSH_CYCLES(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bif2.slave),
      .zf_q(zf_q2), .cf_q(cf_q2), .taken_count(taken_count2)
   );

   int errors = 0;
   int checks = 0;
   logic [17:0] exp_q[$];
   logic        m_z, m_c;
   int          m_cnt;
   int          m_cnt2;

   typedef struct {
      logic        fwe;
      logic        zf;
      logic        cf;
      logic [2:0]  cond;
      logic [17:0] pc;
      logic [9:0]  off;
      logic        taken;
      logic [17:0] tgt;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every redirect pulse must match the oldest expected target.
   always @(negedge clk) begin
      if (rst && bif.redirect_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_redirect", 32'd1, 32'd0);
         end else begin
            chk("redirect_pc", {14'd0, bif.redirect_pc}, {14'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic push_taken(input logic [17:0] tgt);
      exp_q.push_back(tgt);
      m_cnt++;
      m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bif.br_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bif.br_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle_bus();
      bif.flag_we   = 1'b0;
      bif.zf_in     = 1'b0;
      bif.cf_in     = 1'b0;
      bif.br_valid  = 1'b0;
      bif.br_cond   = 3'b000;
      bif.br_pc     = '0;
      bif.br_offset = '0;
   endtask

   task automatic run_vec(input vec_t v);
      wait_ready();
      bif.flag_we   = v.fwe;
      bif.zf_in     = v.zf;
      bif.cf_in     = v.cf;
      bif.br_valid  = 1'b1;
      bif.br_cond   = v.cond;
      bif.br_pc     = v.pc;
      bif.br_offset = v.off;
      if (v.fwe) begin
         m_z = v.zf;
         m_c = v.cf;
      end
      if (v.taken) push_taken(v.tgt);
      @(posedge clk);
      @(negedge clk);
      bif.br_valid = 1'b0;
      bif.flag_we  = 1'b0;
      chk("redirect_valid", {31'd0, bif.redirect_valid}, {31'd0, v.taken});
      chk("flush_first",    {31'd0, bif.flush},          {31'd0, v.taken});
      chk("zf_q",           {31'd0, zf_q},               {31'd0, m_z});
      chk("cf_q",           {31'd0, cf_q},               {31'd0, m_c});
      chk("taken_count",    {16'd0, taken_count},        m_cnt);
      chk("taken_count2",   {30'd0, taken_count2},       m_cnt2);
      if (v.taken) begin
         @(negedge clk);
         chk("flush_second",  {31'd0, bif.flush},          32'd1);
         chk("redirect_once", {31'd0, bif.redirect_valid}, 32'd0);
         chk("ready_in_flush", {31'd0, bif.br_ready},      32'd0);
         @(negedge clk);
         chk("flush_end",     {31'd0, bif.flush},          32'd0);
      end
      chk("ready_idle", {31'd0, bif.br_ready}, 32'd1);
   endtask

   initial begin
      //            fwe   zf    cf    cond    pc        off       taken tgt
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b010, 18'h00010, 10'h004, 1'b1, 18'h00014};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 18'h00010, 10'h004, 1'b0, 18'h00000};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'b010, 18'h00020, 10'h004, 1'b0, 18'h00000};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'b011, 18'h00020, 10'h3F8, 1'b1, 18'h00018};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'b100, 18'h00100, 10'h3FF, 1'b1, 18'h000FF};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'b101, 18'h00100, 10'h010, 1'b0, 18'h00000};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'b110, 18'h00200, 10'h1FF, 1'b1, 18'h003FF};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'b111, 18'h00200, 10'h010, 1'b0, 18'h00000};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b101, 18'h00040, 10'h200, 1'b1, 18'h3FE40};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'b001, 18'h3FFFF, 10'h002, 1'b1, 18'h00001};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 3'b111, 18'h00300, 10'h010, 1'b0, 18'h00000};

      m_z = 1'b0; m_c = 1'b0; m_cnt = 0; m_cnt2 = 0;
      idle_bus();

      @(negedge clk);
      chk("rst_ready",    {31'd0, bif.br_ready},       32'd0);
      chk("rst_redirect", {31'd0, bif.redirect_valid}, 32'd0);
      chk("rst_flush",    {31'd0, bif.flush},          32'd0);
      chk("rst_pc",       {14'd0, bif.redirect_pc},    32'd0);
      chk("rst_flags",    {30'd0, zf_q, cf_q},         32'd0);
      chk("rst_count",    {16'd0, taken_count},        32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Request held through flush, flag write squashed by flush.
      wait_ready();
      bif.flag_we = 1'b1; bif.zf_in = 1'b0; bif.cf_in = 1'b0;
      m_z = 1'b0; m_c = 1'b0;
      @(negedge clk);
      bif.flag_we   = 1'b0;
      bif.br_valid  = 1'b1;
      bif.br_cond   = 3'b001;
      bif.br_pc     = 18'h01000;
      bif.br_offset = 10'h010;
      push_taken(18'h01010);
      @(negedge clk);
      chk("hold_redirect", {31'd0, bif.redirect_valid}, 32'd1);
      chk("hold_ready1",   {31'd0, bif.br_ready},       32'd0);
      bif.flag_we = 1'b1; bif.zf_in = 1'b1; bif.cf_in = 1'b1;
      @(negedge clk);
      chk("hold_no_accept", {31'd0, bif.redirect_valid}, 32'd0);
      chk("hold_ready2",    {31'd0, bif.br_ready},       32'd0);
      chk("squash_flags",   {30'd0, zf_q, cf_q},         32'd0);
      @(negedge clk);
      chk("hold_flush_end", {31'd0, bif.flush},    32'd0);
      chk("hold_ready3",    {31'd0, bif.br_ready}, 32'd1);
      chk("squash_flags2",  {30'd0, zf_q, cf_q},   32'd0);
      bif.br_valid = 1'b0;
      bif.flag_we  = 1'b0;
      @(negedge clk);
      chk("hold_once",  {31'd0, bif.redirect_valid}, 32'd0);
      chk("hold_count", {16'd0, taken_count},        m_cnt);
      chk("sat_count",  {30'd0, taken_count2},       m_cnt2);

      // Reset asserted while in FLUSH.
      bif.br_valid  = 1'b1;
      bif.br_cond   = 3'b001;
      bif.br_pc     = 18'h02000;
      bif.br_offset = 10'h000;
      push_taken(18'h02000);
      @(negedge clk);
      bif.br_valid = 1'b0;
      chk("rf_redirect", {31'd0, bif.redirect_valid}, 32'd1);
      @(negedge clk);
      chk("rf_in_flush", {31'd0, bif.flush}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rf_flush",    {31'd0, bif.flush},          32'd0);
      chk("rf_redirect0",{31'd0, bif.redirect_valid}, 32'd0);
      chk("rf_pc",       {14'd0, bif.redirect_pc},    32'd0);
      chk("rf_count",    {16'd0, taken_count},        32'd0);
      chk("rf_count2",   {30'd0, taken_count2},       32'd0);
      chk("rf_ready",    {31'd0, bif.br_ready},       32'd0);
      m_cnt = 0; m_cnt2 = 0; m_z = 1'b0; m_c = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, bif.br_ready},       32'd1);
      chk("post_rst_flush", {31'd0, bif.flush},          32'd0);
      chk("post_rst_redir", {31'd0, bif.redirect_valid}, 32'd0);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
